arc4_sched: RTL



---
 rtl/arc4_pkg.sv | 24 ++
 rtl/arc4_smem_mux.sv | 49 ++++
 rtl/arc4_sched.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// Shared types and constants for the RC4 sequencer slice.
package arc4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_GO,
        ST_INIT_RUN,
        ST_KSA_GO,
        ST_KSA_RUN,
        ST_PRGA_GO,
        ST_PRGA_RUN,
        ST_ERR
    } arc4_state_t;

    // Owner of the S memory port
    localparam logic [1:0] PH_NONE = 2'd0;
    localparam logic [1:0] PH_INIT = 2'd1;
    localparam logic [1:0] PH_KSA  = 2'd2;
    localparam logic [1:0] PH_PRGA = 2'd3;

    // Cycles a stage has to drop rdy after its en pulse (3-bit counter, keep <= 7)
    localparam int unsigned ACK_TIMEOUT_DEFAULT = 4;

endpackage

// File: rtl/arc4_smem_mux.sv
// S-memory port mux: forwards only the granted stage's request; no grant means an idle port.
module arc4_smem_mux
    import arc4_pkg::*;
(
    input  logic [1:0] phase,
    input  logic [7:0] init_addr,
    input  logic [7:0] init_wrdata,
    input  logic       init_wren,
    input  logic [7:0] ksa_addr,
    input  logic [7:0] ksa_wrdata,
    input  logic       ksa_wren,
    input  logic [7:0] prga_addr,
    input  logic [7:0] prga_wrdata,
    input  logic       prga_wren,
    output logic [7:0] s_addr,
    output logic [7:0] s_wrdata,
    output logic       s_wren
);

    // Select the granted stage; everything is zero when nothing is granted
    always_comb begin
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        case (phase)
            PH_INIT: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            PH_KSA: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            PH_PRGA: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: begin
                s_addr   = '0;
                s_wrdata = '0;
                s_wren   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/arc4_sched.sv
// RC4 top-level sequencer: runs init -> ksa -> prga through en/rdy handshakes
// and grants the single S-memory port to the active stage.
module arc4_sched
    import arc4_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [23:0] key_q,
    output logic        err,
    output logic [1:0]  phase,
    output logic        init_en,
    output logic        ksa_en,
    output logic        prga_en,
    input  logic        init_rdy,
    input  logic        ksa_rdy,
    input  logic        prga_rdy,
    input  logic [7:0]  init_addr,
    input  logic [7:0]  ksa_addr,
    input  logic [7:0]  prga_addr,
    input  logic [7:0]  init_wrdata,
    input  logic [7:0]  ksa_wrdata,
    input  logic [7:0]  prga_wrdata,
    input  logic        init_wren,
    input  logic        ksa_wren,
    input  logic        prga_wren,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wrdata,
    output logic        s_wren,
    input  logic [7:0]  s_rddata,
    output logic [7:0]  rddata
);

    localparam logic [2:0] TMO = 3'(ACK_TIMEOUT);

    arc4_state_t state, state_d;
    logic [1:0]  phase_d;
    logic [23:0] key_d;
    logic        busy_seen, busy_d;
    logic [2:0]  cnt, cnt_d, cnt_inc;
    logic        init_en_d, ksa_en_d, prga_en_d;
    logic        in_run, stage_rdy, run_done, run_tmo;

    assign rdy    = (state == ST_IDLE) || (state == ST_ERR);
    assign err    = (state == ST_ERR);
    assign rddata = s_rddata;

    // Pick the rdy of whichever stage is currently running, and derive done/timeout
    always_comb begin
        in_run    = 1'b0;
        stage_rdy = 1'b0;
        case (state)
            ST_INIT_RUN: begin in_run = 1'b1; stage_rdy = init_rdy; end
            ST_KSA_RUN:  begin in_run = 1'b1; stage_rdy = ksa_rdy;  end
            ST_PRGA_RUN: begin in_run = 1'b1; stage_rdy = prga_rdy; end
            default:     begin in_run = 1'b0; stage_rdy = 1'b0;     end
        endcase
        cnt_inc  = (cnt == 3'd7) ? cnt : 3'(cnt + 3'd1);
        run_done = in_run && busy_seen && stage_rdy;
        run_tmo  = in_run && !busy_seen && stage_rdy && (cnt_inc >= TMO);
    end

    // Next-state, grant and start-pulse logic
    always_comb begin
        state_d   = state;
        phase_d   = phase;
        key_d     = key_q;
        busy_d    = busy_seen;
        cnt_d     = cnt;
        init_en_d = 1'b0;
        ksa_en_d  = 1'b0;
        prga_en_d = 1'b0;

        // Ack tracking is shared by all three RUN states
        if (in_run && !busy_seen) begin
            if (!stage_rdy) busy_d = 1'b1;
            cnt_d = cnt_inc;
        end

        case (state)
            ST_IDLE, ST_ERR: begin
                if (en) begin
                    key_d   = key;
                    state_d = ST_INIT_GO;
                    phase_d = PH_INIT;
                end
            end
            ST_INIT_GO: begin
                if (init_rdy) begin
                    init_en_d = 1'b1;
                    state_d   = ST_INIT_RUN;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                end
            end
            ST_KSA_GO: begin
                if (ksa_rdy) begin
                    ksa_en_d = 1'b1;
                    state_d  = ST_KSA_RUN;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                end
            end
            ST_PRGA_GO: begin
                if (prga_rdy) begin
                    prga_en_d = 1'b1;
                    state_d   = ST_PRGA_RUN;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                end
            end
            ST_INIT_RUN: begin
                if (run_done) begin
                    state_d = ST_KSA_GO;
                    phase_d = PH_KSA;
                end else if (run_tmo) begin
                    state_d = ST_ERR;
                    phase_d = PH_NONE;
                end
            end
            ST_KSA_RUN: begin
                if (run_done) begin
                    state_d = ST_PRGA_GO;
                    phase_d = PH_PRGA;
                end else if (run_tmo) begin
                    state_d = ST_ERR;
                    phase_d = PH_NONE;
                end
            end
            ST_PRGA_RUN: begin
                if (run_done) begin
                    state_d = ST_IDLE;
                    phase_d = PH_NONE;
                end else if (run_tmo) begin
                    state_d = ST_ERR;
                    phase_d = PH_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = PH_NONE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phase     <= PH_NONE;
            key_q     <= '0;
            busy_seen <= 1'b0;
            cnt       <= '0;
            init_en   <= 1'b0;
            ksa_en    <= 1'b0;
            prga_en   <= 1'b0;
        end else begin
            state     <= state_d;
            phase     <= phase_d;
            key_q     <= key_d;
            busy_seen <= busy_d;
            cnt       <= cnt_d;
            init_en   <= init_en_d;
            ksa_en    <= ksa_en_d;
            prga_en   <= prga_en_d;
        end
    end

    arc4_smem_mux u_mux (
        .phase       (phase),
        .init_addr   (init_addr),
        .init_wrdata (init_wrdata),
        .init_wren   (init_wren),
        .ksa_addr    (ksa_addr),
        .ksa_wrdata  (ksa_wrdata),
        .ksa_wren    (ksa_wren),
        .prga_addr   (prga_addr),
        .prga_wrdata (prga_wrdata),
        .prga_wren   (prga_wren),
        .s_addr      (s_addr),
        .s_wrdata    (s_wrdata),
        .s_wren      (s_wren)
    );

endmodule
